// File: rtl/mem_access_pkg.sv
// Shared size codes and FSM state type for the MEM-stage load/store front end.
package mem_access_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_t;

   // Size code 11 behaves as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// byte_lane_unit: little-endian lane extract/extend for loads and lane merge for stores.
module byte_lane_unit
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mword
);

   logic [7:0]  bsel;
   logic [15:0] hsel;

   always_comb begin
      bsel  = rword[{offset, 3'b000} +: 8];
      hsel  = offset[1] ? rword[31:16] : rword[15:0];
      ldata = rword;
      mword = wdata;
      case (size)
         SIZE_BYTE: begin
            ldata = zero_ext ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
            mword = rword;
            mword[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         SIZE_HALF: begin
            ldata = zero_ext ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
            mword = rword;
            if (offset[1]) mword[31:16] = wdata[15:0];
            else           mword[15:0]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end with 2-cycle sub-word RMW stores.
// Optional MEM_MISALIGN_TRAP_EN: flag misaligned ops instead of force-aligning them.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_data_in,
   output logic        dmem_mem_write,
   output logic        dmem_mem_read,
   input  logic [31:0] dmem_data_out,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [4:0]  rsp_rd,
   output logic        misalign_err
);

   state_t state, state_nxt;

   logic [DEPTH_LOG2-1:0] idx_in, rmw_idx;
   logic [31:0]           rmw_word, ldata, mword;
   logic [1:0]            off;
   logic                  mis, wsize, acc, ld_acc, rmw_acc;
   logic                  unused;

   assign unused = ^req_addr[31:DEPTH_LOG2+2];
   assign idx_in = req_addr[DEPTH_LOG2+1:2];
   assign wsize  = is_word(req_size);

`ifdef MEM_MISALIGN_TRAP_EN
   assign off = req_addr[1:0];
   assign mis = ((req_size == SIZE_HALF) & req_addr[0]) |
                (wsize & (req_addr[1:0] != 2'b00));
`else
   // Without trapping, drop the offending low bits to natural alignment.
   always_comb begin
      off = req_addr[1:0];
      if (wsize)                       off = 2'b00;
      else if (req_size == SIZE_HALF)  off = {req_addr[1], 1'b0};
   end
   assign mis = 1'b0;
`endif

   assign acc     = req_valid & (state == IDLE);
   assign ld_acc  = acc & ~req_write & ~mis;
   assign rmw_acc = acc & req_write & ~wsize & ~mis;

   byte_lane_unit u_lane (
      .size     (req_size),
      .zero_ext (req_unsigned),
      .offset   (off),
      .rword    (dmem_data_out),
      .wdata    (req_wdata),
      .ldata    (ldata),
      .mword    (mword)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rmw_acc) state_nxt = RMW;
         RMW:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Enables are gated by rst so a pending RMW write drops immediately.
   always_comb begin
      req_ready      = (state == IDLE);
      dmem_address   = {{(32-DEPTH_LOG2){1'b0}}, idx_in};
      dmem_data_in   = req_wdata;
      dmem_mem_read  = 1'b0;
      dmem_mem_write = 1'b0;
      if (state == RMW) begin
         dmem_address   = {{(32-DEPTH_LOG2){1'b0}}, rmw_idx};
         dmem_data_in   = rmw_word;
         dmem_mem_write = ~rst;
      end else if (acc & ~mis & ~rst) begin
         dmem_mem_read  = ~req_write | ~wsize;
         dmem_mem_write = req_write & wsize;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_rd    <= '0;
         rmw_word  <= '0;
         rmw_idx   <= '0;
      end else begin
         rsp_valid <= ld_acc;
         if (ld_acc) begin
            rsp_rdata <= ldata;
            rsp_rd    <= req_rd;
         end
         if (rmw_acc) begin
            rmw_word <= mword;
            rmw_idx  <= idx_in;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else     misalign_err <= acc & mis;
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a behavioural word-addressed DMEM.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
   logic        dmem_mem_write, dmem_mem_read;
   logic        rsp_valid, misalign_err;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;

   logic [31:0] mem [0:255];
   logic [36:0] sb [$];
   int          compared = 0;
   int          mismatched = 0;
   logic        unused_tb;

   always #5 clk = ~clk;

   assign unused_tb     = ^dmem_address[31:8];
   assign dmem_data_out = mem[dmem_address[7:0]];

   always @(posedge clk)
      if (dmem_mem_write) mem[dmem_address[7:0]] <= dmem_data_in;

   mem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_rd         (req_rd),
      .dmem_address   (dmem_address),
      .dmem_data_in   (dmem_data_in),
      .dmem_mem_write (dmem_mem_write),
      .dmem_mem_read  (dmem_mem_read),
      .dmem_data_out  (dmem_data_out),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_rd         (rsp_rd),
      .misalign_err   (misalign_err)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = d;
      req_rd       = rd;
      #1;
   endtask

   task automatic load(input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [4:0] rd,
                       input logic [31:0] exp);
      drive(1'b0, sz, u, a, 32'h0, rd);
      sb.push_back({rd, exp});
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   // Pops one expected result once rsp_valid appears, within a small cycle budget.
   task automatic expect_rsp(input string tag);
      int n = 0;
      logic [36:0] e;
      while (!rsp_valid && n < 4) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
      if (rsp_valid && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_data"}, rsp_rdata, e[31:0]);
         check({tag, "_rd"}, {27'h0, rsp_rd}, {27'h0, e[36:32]});
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      #12;
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_rd", {27'h0, rsp_rd}, 32'h0);
      check("rst_misalign", {31'h0, misalign_err}, 32'h0);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_wr_en", {31'h0, dmem_mem_write}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Preload word 1 through a plain SW.
      drive(1'b1, 2'b10, 1'b0, 32'd4, 32'h8899_AABB, 5'd0);
      check("sw_wr_en", {31'h0, dmem_mem_write}, 32'h1);
      check("sw_rd_en", {31'h0, dmem_mem_read}, 32'h0);
      check("sw_addr", dmem_address, 32'd1);
      tick();
      check("sw_mem1", mem[1], 32'h8899_AABB);
      check("sw_no_rsp", {31'h0, rsp_valid}, 32'h0);

      // Back-to-back loads, one per cycle.
      load(2'b00, 1'b0, 32'd5, 5'd3, 32'hFFFF_FFAA);
      check("lb_rd_en", {31'h0, dmem_mem_read}, 32'h1);
      tick();
      expect_rsp("lb");
      load(2'b00, 1'b1, 32'd5, 5'd4, 32'h0000_00AA);
      tick();
      expect_rsp("lbu");
      load(2'b01, 1'b0, 32'd6, 5'd5, 32'hFFFF_8899);
      tick();
      expect_rsp("lh");
      load(2'b10, 1'b0, 32'd4, 5'd6, 32'h8899_AABB);
      tick();
      expect_rsp("lw");
      load(2'b01, 1'b1, 32'd4, 5'd7, 32'h0000_AABB);
      tick();
      expect_rsp("lhu");
      idle();
      tick();
      check("idle_no_rsp", {31'h0, rsp_valid}, 32'h0);

      // SB then an immediately following LW held off by the RMW cycle.
      drive(1'b1, 2'b00, 1'b0, 32'd4, 32'h0000_0012, 5'd0);
      check("sb_rd_en", {31'h0, dmem_mem_read}, 32'h1);
      check("sb_wr_en0", {31'h0, dmem_mem_write}, 32'h0);
      tick();
      load(2'b10, 1'b0, 32'd4, 5'd9, 32'h8899_AA12);
      check("rmw_ready", {31'h0, req_ready}, 32'h0);
      check("rmw_wr_en", {31'h0, dmem_mem_write}, 32'h1);
      check("rmw_rd_en", {31'h0, dmem_mem_read}, 32'h0);
      check("rmw_addr", dmem_address, 32'd1);
      check("rmw_data", dmem_data_in, 32'h8899_AA12);
      tick();
      check("sb_mem1", mem[1], 32'h8899_AA12);
      check("sb_ready", {31'h0, req_ready}, 32'h1);
      check("sb_no_rsp", {31'h0, rsp_valid}, 32'h0);
      tick();
      idle();
      expect_rsp("lw_after_sb");

      // SH into the upper half of a freshly restored word 1.
      drive(1'b1, 2'b10, 1'b0, 32'd4, 32'h8899_AABB, 5'd0);
      tick();
      drive(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000_1234, 5'd0);
      tick();
      idle();
      tick();
      check("sh_mem1", mem[1], 32'h1234_AABB);

      // Index wrap: byte 1024 maps to word 0.
      drive(1'b1, 2'b10, 1'b0, 32'd1024, 32'hCAFE_F00D, 5'd0);
      check("wrap_addr", dmem_address, 32'd0);
      tick();
      check("wrap_mem0", mem[0], 32'hCAFE_F00D);

      // Reset arriving in the RMW cycle drops the pending write.
      drive(1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344, 5'd0);
      tick();
      drive(1'b1, 2'b00, 1'b0, 32'd8, 32'h0000_0055, 5'd0);
      tick();
      idle();
      check("rr_wr_before", {31'h0, dmem_mem_write}, 32'h1);
      rst = 1'b1;
      #1;
      check("rr_wr_drop", {31'h0, dmem_mem_write}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("rr_mem2", mem[2], 32'h1122_3344);
      check("rr_ready", {31'h0, req_ready}, 32'h1);
      check("rr_rdata", rsp_rdata, 32'h0);
      check("rr_valid", {31'h0, rsp_valid}, 32'h0);

      load(2'b10, 1'b0, 32'd4, 5'd11, 32'h1234_AABB);
      tick();
      expect_rsp("lw_pre_mis");

`ifdef MEM_MISALIGN_TRAP_EN
      drive(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 5'd12);
      check("mis_rd_en", {31'h0, dmem_mem_read}, 32'h0);
      check("mis_wr_en", {31'h0, dmem_mem_write}, 32'h0);
      tick();
      idle();
      check("mis_err", {31'h0, misalign_err}, 32'h1);
      check("mis_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check("mis_rdata", rsp_rdata, 32'h1234_AABB);
      tick();
      check("mis_err_pulse", {31'h0, misalign_err}, 32'h0);
`else
      load(2'b10, 1'b0, 32'd6, 5'd12, 32'h1234_AABB);
      tick();
      check("mis_err_tied", {31'h0, misalign_err}, 32'h0);
      expect_rsp("lw_mis_align");
      load(2'b01, 1'b0, 32'd7, 5'd13, 32'h0000_1234);
      tick();
      expect_rsp("lh_mis_align");
      idle();
      tick();
`endif

      check("sb_empty", sb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
